// File: rtl/vga_pixel_shifter_pkg.sv
// Shared definitions for the VGA pixel shifter: FSM state encoding, default geometry
// and the framebuffer word-address helper.
package vga_pixel_shifter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    READY,
    ACTIVE,
    BLANK
  } vga_state_e;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned WORD_BITS    = 32;

  // Word n of a line lives at base + line*words_pl + n; the sum wraps modulo 2^32.
  function automatic logic [31:0] word_address(
    input logic [31:0] base,
    input logic [9:0]  line,
    input logic [9:0]  n,
    input int unsigned words_pl
  );
    return base + (32'(line) * 32'(words_pl)) + 32'(n);
  endfunction

endpackage

// File: rtl/vga_pixel_shifter_word_buffer.sv
// Two-entry front/back word register feeding the pixel serializer; the front word is
// the one being shown, the back word is the prefetched successor.
module vga_pixel_shifter_word_buffer
  import vga_pixel_shifter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 load_i,
  input  logic [WORD_BITS-1:0] load_data_i,
  input  logic                 advance_i,
  output logic [WORD_BITS-1:0] front_o,
  output logic                 front_valid_o,
  output logic                 back_valid_o,
  output logic                 underflow_o
);

  logic [WORD_BITS-1:0] front_q, front_d;
  logic [WORD_BITS-1:0] back_q, back_d;
  logic                 front_valid_q, front_valid_d;
  logic                 back_valid_q, back_valid_d;

  // On an advance with nothing in back, a word landing in the same cycle bypasses
  // straight into front; otherwise front is filled with an all-black word that still
  // counts as occupied, so a late word queues behind it.
  always_comb begin
    front_d       = front_q;
    back_d        = back_q;
    front_valid_d = front_valid_q;
    back_valid_d  = back_valid_q;

    if (flush_i) begin
      front_d       = '0;
      back_d        = '0;
      front_valid_d = 1'b0;
      back_valid_d  = 1'b0;
    end else if (advance_i) begin
      front_valid_d = 1'b1;
      if (back_valid_q) begin
        front_d      = back_q;
        back_valid_d = load_i;
        if (load_i) begin
          back_d = load_data_i;
        end
      end else if (load_i) begin
        front_d      = load_data_i;
        back_valid_d = 1'b0;
      end else begin
        front_d = '0;
      end
    end else if (load_i) begin
      if (!front_valid_q) begin
        front_d       = load_data_i;
        front_valid_d = 1'b1;
      end else if (!back_valid_q) begin
        back_d       = load_data_i;
        back_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      front_q       <= '0;
      back_q        <= '0;
      front_valid_q <= 1'b0;
      back_valid_q  <= 1'b0;
    end else begin
      front_q       <= front_d;
      back_q        <= back_d;
      front_valid_q <= front_valid_d;
      back_valid_q  <= back_valid_d;
    end
  end

  assign front_o       = front_q;
  assign front_valid_o = front_valid_q;
  assign back_valid_o  = back_valid_q;
  assign underflow_o   = !flush_i && advance_i && !back_valid_q && !load_i;

endmodule

// File: rtl/vga_pixel_shifter.sv
// Fetches 32-bit framebuffer words ahead of the beam and serializes them MSB first,
// one 1-bpp pixel per clock, during active video.
module vga_pixel_shifter
  import vga_pixel_shifter_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter logic [31:0] FB_BASE  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  output logic        word_req,
  output logic [31:0] word_addr,
  input  logic [31:0] word_data,
  input  logic        word_valid,
  output logic        pixel_out,
  output logic        pixel_active,
  output logic        underflow
);

  localparam int unsigned WORDS_PL   = H_ACTIVE / WORD_BITS;
  localparam logic [9:0]  WORDS_N    = 10'(WORDS_PL);
  localparam logic [9:0]  WORDS_LAST = 10'(WORDS_PL - 1);
  localparam logic [9:0]  V_START    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_LAST     = 10'(V_ACTIVE - 1);

  vga_state_e  state_q, state_d;
  logic [4:0]  bit_idx_q, bit_idx_d;
  logic [9:0]  word_idx_q, word_idx_d;
  logic [9:0]  fetch_idx_q, fetch_idx_d;
  logic [9:0]  line_q, line_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        pixel_q, pixel_d;
  logic        active_q, active_d;
  logic        underflow_q, underflow_d;

  logic        buf_flush, buf_load, buf_advance, buf_underflow;
  logic        front_valid, back_valid;
  logic [31:0] front_word;
  logic [1:0]  occupancy;
  logic        fetch_en;

  vga_pixel_shifter_word_buffer u_word_buffer (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (buf_flush),
    .load_i        (buf_load),
    .load_data_i   (word_data),
    .advance_i     (buf_advance),
    .front_o       (front_word),
    .front_valid_o (front_valid),
    .back_valid_o  (back_valid),
    .underflow_o   (buf_underflow)
  );

  // A new fetch is allowed only when the buffer has a free slot and nothing is in flight.
  assign buf_load  = req_q && word_valid;
  assign occupancy = {1'b0, front_valid} + {1'b0, back_valid};
  assign fetch_en  = (state_q == PRIME) || (state_q == READY) || (state_q == ACTIVE);

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    word_idx_d  = word_idx_q;
    fetch_idx_d = fetch_idx_q;
    line_d      = line_q;
    req_d       = req_q;
    addr_d      = addr_q;
    pixel_d     = 1'b0;
    active_d    = 1'b0;
    buf_flush   = 1'b0;
    buf_advance = 1'b0;
    underflow_d = underflow_q | buf_underflow;

    if (req_q && word_valid) begin
      req_d = 1'b0;
    end

    if (fetch_en && !req_q && (occupancy != 2'd2) && (fetch_idx_q < WORDS_N)) begin
      req_d       = 1'b1;
      addr_d      = word_address(FB_BASE, line_q, fetch_idx_q, WORDS_PL);
      fetch_idx_d = fetch_idx_q + 10'd1;
    end

    unique case (state_q)
      IDLE: begin
        if ((h_count == 10'd0) && (v_count == V_START)) begin
          state_d     = PRIME;
          line_d      = '0;
          word_idx_d  = '0;
          fetch_idx_d = '0;
          bit_idx_d   = '0;
          buf_flush   = 1'b1;
        end
      end
      PRIME: begin
        if (front_valid && back_valid) begin
          state_d = READY;
        end
      end
      READY: begin
        if ((h_count == 10'd0) && (v_count == line_q)) begin
          pixel_d   = front_word[~bit_idx_q];
          active_d  = 1'b1;
          bit_idx_d = bit_idx_q + 5'd1;
          state_d   = ACTIVE;
        end
      end
      ACTIVE: begin
        pixel_d   = front_word[~bit_idx_q];
        active_d  = 1'b1;
        bit_idx_d = bit_idx_q + 5'd1;
        if (bit_idx_q == 5'd31) begin
          if (word_idx_q == WORDS_LAST) begin
            state_d = BLANK;
          end else begin
            buf_advance = 1'b1;
            word_idx_d  = word_idx_q + 10'd1;
          end
        end
      end
      BLANK: begin
        // Hold here until a straggling fetch has returned so it cannot land in the next line.
        buf_flush = 1'b1;
        if (!req_q) begin
          word_idx_d  = '0;
          fetch_idx_d = '0;
          bit_idx_d   = '0;
          if (line_q == V_LAST) begin
            state_d = IDLE;
          end else begin
            line_d  = line_q + 10'd1;
            state_d = PRIME;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      word_idx_q  <= '0;
      fetch_idx_q <= '0;
      line_q      <= '0;
      req_q       <= 1'b0;
      addr_q      <= FB_BASE;
      pixel_q     <= 1'b0;
      active_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      word_idx_q  <= word_idx_d;
      fetch_idx_q <= fetch_idx_d;
      line_q      <= line_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      pixel_q     <= pixel_d;
      active_q    <= active_d;
      underflow_q <= underflow_d;
    end
  end

  assign word_req     = req_q;
  assign word_addr    = addr_q;
  assign pixel_out    = pixel_q;
  assign pixel_active = active_q;
  assign underflow    = underflow_q;

endmodule
